tinytpu_serial_mmu: RTL and testbench
=====================================

// Module: tinytpu_serial_mmu
// PURPOSE
// - Parametrised successor of the 2x2 serial tinytpu core: loads two NxN operand matrices X, Y over
//   LANES-wide serial links, computes Z = X*Y (signed or unsigned) with a single time-multiplexed MAC,
//   then streams Z back over LANES-wide serial output under host flow control.
// - Sits directly behind the pad wrapper; all host traffic is bit-serial on dedicated pins.
// PARAMETERS
// - D_W    8   operand element width (bits)
// - N      2   matrix dimension (N>=2)
// - LANES  1   serial lanes per direction; N*N*D_W and N*N*ACC_W must each be divisible by LANES
// - ACC_W  2*D_W+$clog2(N)  accumulator / result element width (derived localparam, not overridable)
// PORTS
// - clk          in   1      clock, all logic on rising edge
// - rst          in   1      synchronous reset, active-high
// - data_in_x    in   LANES  X serial beat; lane LANES-1 carries the earliest (most significant) bit
// - data_in_y    in   LANES  Y serial beat, same framing as X
// - load_en      in   1      beat valid for data_in_x/data_in_y
// - init         in   1      start-compute pulse
// - signed_mode  in   1      1 = two's-complement operands/results; sampled when init accepted
// - tx_en        in   1      host accepts current output beat
// - data_out_z   out  LANES  Z serial beat, same framing as input
// - tx_ready     out  1      data_out_z holds a valid beat
// - busy         out  1      high in COMPUTE and TX
// BEHAVIOUR
// - Reset: state=IDLE, beat/index counters=0, accumulator=0, data_out_z=0, tx_ready=0, busy=0.
// - Framing: elements row-major (r0c0, r0c1, ...), each element MSB-first; LANES bits per beat.
//   Load frame = LB = N*N*D_W/LANES beats; output frame = TB = N*N*ACC_W/LANES beats.
// - FSM: IDLE -> LOAD on first load_en beat; LOAD -> READY when beat LB accepted;
//   READY -> COMPUTE on init; COMPUTE -> TX after N^3 MAC cycles; TX -> IDLE after beat TB accepted.
// - LOAD: each load_en cycle shifts one beat into X and Y regs, beat counter +1; load_en low = hold
//   (gaps allowed, no timeout). init during IDLE/LOAD ignored (no partial-matrix compute).
// - READY: load_en restarts a fresh load (counter to 1, beat shifted in); init+load_en same cycle ->
//   init wins, beat discarded.
// - COMPUTE: exactly N^3 cycles, one MAC/cycle, loop order i (row), j (col), k (inner), k innermost.
//   acc cleared at k=0 (acc = product), product sign/zero-extended to ACC_W per signed_mode;
//   at k=N-1 final sum written into Z[i][j]. No overflow possible by ACC_W construction; no saturation.
//   load_en, init, tx_en ignored.
// - TX: tx_ready=1 from first cycle after last MAC; data_out_z = current beat (registered);
//   tx_en=1 advances to next beat next cycle; tx_en=0 holds beat and tx_ready (backpressure unbounded).
//   After last beat accepted, tx_ready=0, data_out_z=0, busy=0 next cycle. load_en/init ignored.
// - Latency: init accepted at cycle t -> tx_ready first high at t+1+N^3.
// - X/Y operand regs retained after TX; a new full load is required before the next init.
// - rst mid-operation (any state): immediate return to reset values; partial frames discarded.
// STRUCTURE
// - tinytpu_pkg: state enum (IDLE, LOAD, READY, COMPUTE, TX), acc_w(D_W,N) function, clog2 helpers.
// - Sub-module tinytpu_mac: D_W x D_W multiply, sign/zero extend, ACC_W accumulate with clear input.
// - Top holds FSM, beat counters, i/j/k counters, X/Y/Z shift-register arrays, elaboration-time
//   divisibility checks on LANES.
// TESTING (N=2, D_W=8, ACC_W=17 unless stated)
// - LANES=1 unsigned: X=[[1,2],[3,4]], Y=[[5,6],[7,8]], init -> tx_ready at init+9, Z=[[19,22],[43,50]].
// - Signed: X=[[-1,2],[0,-128]], Y=[[3,0],[-128,1]] -> Z=[[-259,2],[16384,-128]] as 17-bit two's comp.
// - Extremes unsigned: all X,Y=255 -> every Z=130050; signed all=-128 -> every Z=32768.
// - Backpressure: tx_en toggled 1,0,0,1 pattern -> beats held while tx_en=0, TB=68 beats, none lost/duped.
// - Load gaps and init-too-early: load_en gaps of 3 cycles, init pulsed mid-load -> ignored, result intact;
//   LANES=4 variant same matrices -> identical Z.
// - rst asserted mid-COMPUTE and mid-TX -> all outputs 0 next cycle; init without reload ignored.

Source files
------------

// File: rtl/tinytpu_pkg.sv
// Shared types and elaboration-time helpers for the serial tinytpu matrix-multiply core.
package tinytpu_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_READY,
    S_COMPUTE,
    S_TX
  } state_e;

  // Counter width that stays at least one bit wide for tiny ranges.
  function automatic int clog2_min1(input int v);
    return (v <= 2) ? 1 : $clog2(v);
  endfunction

  // Accumulator wide enough that N full-scale products can never overflow.
  function automatic int acc_w(input int d_w, input int n);
    return 2 * d_w + $clog2(n);
  endfunction

endpackage

// File: rtl/tinytpu_mac.sv
// Single multiply-accumulate slice: D_W x D_W product, sign/zero extended, ACC_W accumulator.
module tinytpu_mac #(
  parameter int D_W   = 8,
  parameter int ACC_W = 17
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_en,
  input  logic             i_clr,
  input  logic             i_signed,
  input  logic [D_W-1:0]   i_a,
  input  logic [D_W-1:0]   i_b,
  output logic [ACC_W-1:0] o_sum
);

  logic signed [D_W:0]     w_a_ext;
  logic signed [D_W:0]     w_b_ext;
  logic signed [ACC_W-1:0] w_prod;
  logic [ACC_W-1:0]        r_acc;

  // One extra top bit turns both modes into a single signed multiply.
  assign w_a_ext = {i_signed & i_a[D_W-1], i_a};
  assign w_b_ext = {i_signed & i_b[D_W-1], i_b};
  assign w_prod  = ACC_W'(w_a_ext) * ACC_W'(w_b_ext);
  assign o_sum   = i_clr ? $unsigned(w_prod) : r_acc + $unsigned(w_prod);

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (rst) begin
      r_acc <= '0;
    end else if (i_en) begin
      r_acc <= o_sum;
    end
  end

endmodule

// File: rtl/tinytpu_serial_mmu.sv
// Serial-link NxN matrix multiplier: loads X and Y bit-serially, computes Z = X*Y on one MAC,
// and streams Z back under host flow control.
module tinytpu_serial_mmu
  import tinytpu_pkg::*;
#(
  parameter int D_W   = 8,
  parameter int N     = 2,
  parameter int LANES = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [LANES-1:0] data_in_x,
  input  logic [LANES-1:0] data_in_y,
  input  logic             load_en,
  input  logic             init,
  input  logic             signed_mode,
  input  logic             tx_en,
  output logic [LANES-1:0] data_out_z,
  output logic             tx_ready,
  output logic             busy
);

  localparam int ACC_W = acc_w(D_W, N);
  localparam int NN    = N * N;
  localparam int XW    = NN * D_W;
  localparam int ZW    = NN * ACC_W;
  localparam int LB    = XW / LANES;
  localparam int TB    = ZW / LANES;
  localparam int IW    = clog2_min1(N);
  localparam int EW    = clog2_min1(NN);
  localparam int BW    = clog2_min1(TB);
  localparam logic [IW-1:0] N_LAST = IW'(N - 1);

  if (N < 2) begin : g_chk_n
    $error("tinytpu_serial_mmu: N must be at least 2");
  end
  if ((XW % LANES) != 0) begin : g_chk_x_lanes
    $error("tinytpu_serial_mmu: LANES must divide N*N*D_W");
  end
  if ((ZW % LANES) != 0) begin : g_chk_z_lanes
    $error("tinytpu_serial_mmu: LANES must divide N*N*ACC_W");
  end

  state_e           r_state, w_state_next;
  logic [XW-1:0]    r_x, r_y;
  logic [ZW-1:0]    r_z, w_z_wr, w_z_shift;
  logic [LANES-1:0] r_dout;
  logic [BW-1:0]    r_beat, w_beat_inc;
  logic [IW-1:0]    r_i, r_j, r_k;
  logic             r_signed;

  logic             w_load_acc, w_start, w_tx_acc;
  logic             w_k_last, w_mac_last, w_tx_last, w_computing;
  logic [EW-1:0]    w_xi, w_yi, w_zi;
  logic [D_W-1:0]   w_a, w_b;
  logic [ACC_W-1:0] w_sum;

  assign w_computing = (r_state == S_COMPUTE);
  assign w_k_last    = (r_k == N_LAST);
  assign w_mac_last  = w_k_last && (r_j == N_LAST) && (r_i == N_LAST);
  assign w_tx_last   = (r_beat == BW'(TB - 1));

  assign w_xi = EW'(r_i) * EW'(N) + EW'(r_k);
  assign w_yi = EW'(r_k) * EW'(N) + EW'(r_j);
  assign w_zi = EW'(r_i) * EW'(N) + EW'(r_j);

  // Element e (row-major) sits at the top of the shift register, earliest bit highest.
  always_comb begin
    // NOTE: every signal written here gets a default first, so no path infers a latch.
    w_a    = '0;
    w_b    = '0;
    w_z_wr = r_z;
    for (int e = 0; e < NN; e++) begin
      if (w_xi == EW'(e)) w_a = r_x[XW-1-e*D_W -: D_W];
      if (w_yi == EW'(e)) w_b = r_y[XW-1-e*D_W -: D_W];
      if (w_zi == EW'(e)) w_z_wr[ZW-1-e*ACC_W -: ACC_W] = w_sum;
    end
  end

  assign w_z_shift = r_z << LANES;

  tinytpu_mac #(
    .D_W   (D_W),
    .ACC_W (ACC_W)
  ) u_mac (
    .clk      (clk),
    .rst      (rst),
    .i_en     (w_computing),
    .i_clr    (r_k == '0),
    .i_signed (r_signed),
    .i_a      (w_a),
    .i_b      (w_b),
    .o_sum    (w_sum)
  );

  always_comb begin
    w_state_next = r_state;
    w_load_acc   = 1'b0;
    w_beat_inc   = r_beat + BW'(1);
    w_start      = 1'b0;
    w_tx_acc     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (load_en) begin
          w_load_acc = 1'b1;
          w_beat_inc = BW'(1);
        end
      end
      S_LOAD: begin
        if (load_en) w_load_acc = 1'b1;
      end
      S_READY: begin
        // init outranks a same-cycle beat; a lone beat restarts the frame.
        if (init) begin
          w_start = 1'b1;
        end else if (load_en) begin
          w_load_acc = 1'b1;
          w_beat_inc = BW'(1);
        end
      end
      S_COMPUTE: begin
        if (w_mac_last) w_state_next = S_TX;
      end
      S_TX: begin
        if (tx_en) begin
          w_tx_acc = 1'b1;
          if (w_tx_last) w_state_next = S_IDLE;
        end
      end
      default: w_state_next = S_IDLE;
    endcase
    if (w_load_acc) w_state_next = (w_beat_inc == BW'(LB)) ? S_READY : S_LOAD;
    if (w_start)    w_state_next = S_COMPUTE;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_beat   <= '0;
      r_i      <= '0;
      r_j      <= '0;
      r_k      <= '0;
      r_dout   <= '0;
      r_signed <= 1'b0;
    end else begin
      r_state <= w_state_next;
      if (w_load_acc) r_beat <= w_beat_inc;
      if (w_start) begin
        r_signed <= signed_mode;
        r_beat   <= '0;
        r_i      <= '0;
        r_j      <= '0;
        r_k      <= '0;
      end
      if (w_computing) begin
        if (w_k_last) begin
          r_k <= '0;
          if (r_j == N_LAST) begin
            r_j <= '0;
            r_i <= w_mac_last ? '0 : r_i + IW'(1);
          end else begin
            r_j <= r_j + IW'(1);
          end
        end else begin
          r_k <= r_k + IW'(1);
        end
        if (w_mac_last) r_dout <= w_z_wr[ZW-1 -: LANES];
      end
      if (w_tx_acc) begin
        r_beat <= w_tx_last ? '0 : r_beat + BW'(1);
        r_dout <= w_tx_last ? '0 : w_z_shift[ZW-1 -: LANES];
      end
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: operand/result arrays carry no reset; the FSM never exposes them before a full load/compute.
    if (!rst && w_load_acc) begin
      r_x <= (r_x << LANES) | XW'(data_in_x);
      r_y <= (r_y << LANES) | XW'(data_in_y);
    end
    if (!rst && w_computing && w_k_last) begin
      r_z <= w_z_wr;
    end else if (!rst && w_tx_acc) begin
      r_z <= w_z_shift;
    end
  end

  assign data_out_z = r_dout;
  assign tx_ready   = (r_state == S_TX);
  assign busy       = (r_state == S_COMPUTE) || (r_state == S_TX);

endmodule

// File: tb/tb_tinytpu_serial_mmu.sv
// Randomised bench for tinytpu_serial_mmu: a LANES=1 and a LANES=4 instance checked against a
// plain-arithmetic matrix-product model.
module tb_tinytpu_serial_mmu;

  localparam int NN    = 4;
  localparam int ACC_W = 17;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst = 1'b1, load_en = 1'b0, init = 1'b0, signed_mode = 1'b0, tx_en = 1'b0;
  logic       use_l4 = 1'b0;
  logic [3:0] din_x = '0, din_y = '0;
  logic [0:0] z1;
  logic [3:0] z4, z;
  logic       rdy1, rdy4, bsy1, bsy4, rdy, bsy;

  int checks   = 0;
  int failures = 0;
  int lanes    = 1;
  bit sgn      = 1'b0;
  int mx[NN], my[NN], zexp[NN];
  logic [3:0] exp_q[$];

  tinytpu_serial_mmu #(.D_W(8), .N(2), .LANES(1)) u_dut1 (
    .clk(clk), .rst(rst), .data_in_x(din_x[0:0]), .data_in_y(din_y[0:0]),
    .load_en(load_en & ~use_l4), .init(init & ~use_l4), .signed_mode(signed_mode),
    .tx_en(tx_en & ~use_l4), .data_out_z(z1), .tx_ready(rdy1), .busy(bsy1)
  );

  tinytpu_serial_mmu #(.D_W(8), .N(2), .LANES(4)) u_dut4 (
    .clk(clk), .rst(rst), .data_in_x(din_x), .data_in_y(din_y),
    .load_en(load_en & use_l4), .init(init & use_l4), .signed_mode(signed_mode),
    .tx_en(tx_en & use_l4), .data_out_z(z4), .tx_ready(rdy4), .busy(bsy4)
  );

  assign z   = use_l4 ? z4 : {3'b000, z1};
  assign rdy = use_l4 ? rdy4 : rdy1;
  assign bsy = use_l4 ? bsy4 : bsy1;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_lanes(input int l);
    lanes  = l;
    use_l4 = (l == 4);
  endtask

  function automatic longint elem(input int v);
    logic [7:0] b;
    b = v[7:0];
    if (sgn) return longint'($signed(b));
    return longint'(b);
  endfunction

  // Z = X * Y from the matrix definition.
  task automatic model_z();
    for (int r = 0; r < 2; r++)
      for (int c = 0; c < 2; c++) begin
        longint s = 0;
        for (int k = 0; k < 2; k++) s += elem(mx[r*2+k]) * elem(my[k*2+c]);
        zexp[r*2+c] = int'(s);
      end
  endtask

  // Row-major, MSB-first ACC_W-bit stream chopped into beats, earliest bit on the top lane.
  task automatic build_beats();
    bit bits[$];
    exp_q.delete();
    for (int e = 0; e < NN; e++)
      for (int b = ACC_W - 1; b >= 0; b--) bits.push_back(zexp[e][b]);
    for (int beat = 0; beat < bits.size() / lanes; beat++) begin
      logic [3:0] v;
      v = '0;
      for (int l = 0; l < lanes; l++) v[lanes-1-l] = bits[beat*lanes+l];
      exp_q.push_back(v);
    end
  endtask

  task automatic load_frame(input int gap, input bit poke_init);
    bit bx[$], by[$];
    int nb;
    for (int e = 0; e < NN; e++)
      for (int b = 7; b >= 0; b--) begin
        bx.push_back(mx[e][b]);
        by.push_back(my[e][b]);
      end
    nb = 32 / lanes;
    for (int beat = 0; beat < nb; beat++) begin
      din_x = '0;
      din_y = '0;
      for (int l = 0; l < lanes; l++) begin
        din_x[lanes-1-l] = bx[beat*lanes+l];
        din_y[lanes-1-l] = by[beat*lanes+l];
      end
      load_en = 1'b1;
      tick();
      load_en = 1'b0;
      for (int g = 0; g < gap; g++) begin
        din_x = 4'($urandom);
        din_y = 4'($urandom);
        init  = poke_init && (g == 1) && (beat < nb - 1);
        tick();
        init  = 1'b0;
      end
    end
  endtask

  task automatic start_compute(input string name, input bit with_load);
    int cyc;
    init        = 1'b1;
    load_en     = with_load;
    din_x       = 4'($urandom);
    din_y       = 4'($urandom);
    signed_mode = sgn;
    tick();
    init    = 1'b0;
    load_en = 1'b0;
    checks++;
    if (bsy !== 1'b1) begin
      failures++;
      $display("FAIL %s busy after init: got %b, expected 1", name, bsy);
    end
    cyc = 1;
    while (rdy !== 1'b1 && cyc < 40) begin
      tx_en       = 1'($urandom);
      load_en     = 1'($urandom);
      signed_mode = 1'($urandom);
      tick();
      cyc++;
    end
    tx_en   = 1'b0;
    load_en = 1'b0;
    checks++;
    if (cyc !== 9) begin
      failures++;
      $display("FAIL %s latency: tx_ready after %0d cycles, expected 9", name, cyc);
    end
  endtask

  // mode 0: always accept; 1: tx_en pattern 1,0,0,1; 2: random tx_en.
  task automatic receive(input string name, input int mode);
    int b = 0, cyc = 0, nb;
    bit te;
    nb = exp_q.size();
    while (b < nb && cyc < 1000) begin
      checks++;
      if (rdy !== 1'b1 || z !== exp_q[b]) begin
        failures++;
        $display("FAIL %s beat %0d: got z=%h ready=%b, expected z=%h ready=1", name, b, z, rdy, exp_q[b]);
      end
      case (mode)
        0:       te = 1'b1;
        1:       te = ((cyc % 4) == 0) || ((cyc % 4) == 3);
        default: te = 1'($urandom);
      endcase
      load_en = 1'($urandom);
      init    = 1'($urandom);
      tx_en   = te;
      tick();
      tx_en   = 1'b0;
      load_en = 1'b0;
      init    = 1'b0;
      if (te) b++;
      cyc++;
    end
    checks++;
    if (b !== nb) begin
      failures++;
      $display("FAIL %s beat count: accepted %0d, expected %0d", name, b, nb);
    end
    checks++;
    if (rdy !== 1'b0 || bsy !== 1'b0 || z !== 4'h0) begin
      failures++;
      $display("FAIL %s after frame: ready=%b busy=%b z=%h, expected 0 0 0", name, rdy, bsy, z);
    end
  endtask

  task automatic run_frame(input string name, input int gap, input bit poke, input int mode);
    load_frame(gap, poke);
    checks++;
    if (bsy !== 1'b0 || rdy !== 1'b0) begin
      failures++;
      $display("FAIL %s idle after load: busy=%b ready=%b, expected 0 0", name, bsy, rdy);
    end
    start_compute(name, 1'b0);
    build_beats();
    receive(name, mode);
  endtask

  task automatic check_zero(input string name);
    checks++;
    if (rdy !== 1'b0 || bsy !== 1'b0 || z !== 4'h0) begin
      failures++;
      $display("FAIL %s: ready=%b busy=%b z=%h, expected 0 0 0", name, rdy, bsy, z);
    end
  endtask

  task automatic check_init_ignored(input string name);
    bit seen = 1'b0;
    init = 1'b1;
    tick();
    init = 1'b0;
    for (int c = 0; c < 12; c++) begin
      if (bsy !== 1'b0 || rdy !== 1'b0) seen = 1'b1;
      tick();
    end
    checks++;
    if (seen) begin
      failures++;
      $display("FAIL %s: busy/ready rose, expected init ignored", name);
    end
  endtask

  task automatic basic_mats();
    sgn  = 1'b0;
    mx   = '{1, 2, 3, 4};
    my   = '{5, 6, 7, 8};
    zexp = '{19, 22, 43, 50};
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    check_zero("reset");
    rst = 1'b0;
    tick();
    check_zero("reset_release");
  endtask

  task automatic test_unsigned();
    set_lanes(1);
    basic_mats();
    run_frame("unsigned_basic", 0, 1'b0, 0);
  endtask

  task automatic test_signed();
    set_lanes(1);
    sgn  = 1'b1;
    mx   = '{-1, 2, 0, -128};
    my   = '{3, 0, -128, 1};
    zexp = '{-259, 2, 16384, -128};
    run_frame("signed_basic", 1, 1'b0, 2);
  endtask

  task automatic test_extremes();
    set_lanes(1);
    sgn  = 1'b0;
    mx   = '{255, 255, 255, 255};
    my   = '{255, 255, 255, 255};
    zexp = '{130050, 130050, 130050, 130050};
    run_frame("extreme_unsigned", 0, 1'b0, 2);
    sgn  = 1'b1;
    mx   = '{-128, -128, -128, -128};
    my   = '{-128, -128, -128, -128};
    zexp = '{32768, 32768, 32768, 32768};
    run_frame("extreme_signed", 0, 1'b0, 2);
  endtask

  task automatic test_backpressure();
    set_lanes(1);
    basic_mats();
    run_frame("backpressure", 0, 1'b0, 1);
  endtask

  task automatic test_gaps_early_init();
    set_lanes(1);
    basic_mats();
    check_init_ignored("init_in_idle");
    run_frame("gaps_early_init", 3, 1'b1, 0);
    // init and a stray beat together in READY: init must win and the operands stay intact.
    load_frame(0, 1'b0);
    start_compute("init_beats_load", 1'b1);
    build_beats();
    receive("init_beats_load", 0);
  endtask

  task automatic test_lanes4();
    set_lanes(4);
    basic_mats();
    run_frame("lanes4_unsigned", 3, 1'b1, 1);
    sgn  = 1'b1;
    mx   = '{-1, 2, 0, -128};
    my   = '{3, 0, -128, 1};
    zexp = '{-259, 2, 16384, -128};
    run_frame("lanes4_signed", 0, 1'b0, 2);
    set_lanes(1);
  endtask

  task automatic test_rst_mid();
    set_lanes(1);
    basic_mats();
    load_frame(0, 1'b0);
    init = 1'b1;
    tick();
    init = 1'b0;
    repeat (3) tick();
    rst = 1'b1;
    tick();
    check_zero("rst_mid_compute");
    rst = 1'b0;
    check_init_ignored("init_after_rst_compute");
    load_frame(0, 1'b0);
    start_compute("rst_mid_tx_setup", 1'b0);
    tx_en = 1'b1;
    repeat (10) tick();
    tx_en = 1'b0;
    rst   = 1'b1;
    tick();
    check_zero("rst_mid_tx");
    rst = 1'b0;
    check_init_ignored("init_after_rst_tx");
    run_frame("recover_after_rst", 0, 1'b0, 0);
  endtask

  task automatic test_random();
    for (int it = 0; it < 10; it++) begin
      set_lanes(($urandom_range(0, 1) == 1) ? 4 : 1);
      sgn = 1'($urandom);
      for (int e = 0; e < NN; e++) begin
        mx[e] = int'($urandom_range(0, 255));
        my[e] = int'($urandom_range(0, 255));
      end
      model_z();
      run_frame($sformatf("random_%0d", it), int'($urandom_range(0, 2)), 1'($urandom), 2);
    end
    set_lanes(1);
  endtask

  initial begin
    test_reset();
    test_unsigned();
    test_signed();
    test_extremes();
    test_backpressure();
    test_gaps_early_init();
    test_lanes4();
    test_rst_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
